// File: rtl/nonce_scheduler_if.sv
// Launch/result handshake between the nonce scheduler and the SHA-256d hash core.
// The scheduler drives the master side and the hash core drives the slave side.
interface nonce_scheduler_if;
  logic         core_start;
  logic [31:0]  core_nonce;
  logic         core_done;
  logic [255:0] core_hash;

  modport master (
    output core_start,
    output core_nonce,
    input  core_done,
    input  core_hash
  );

  modport slave (
    input  core_start,
    input  core_nonce,
    output core_done,
    output core_hash
  );
endinterface

// File: rtl/nonce_scheduler.sv
// Bounded, abortable nonce search. For each nonce it launches the hash core, waits with a
// timeout guard, and compares the returned hash against the latched target.
module nonce_scheduler #(
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        nonce_base,
  input  logic [31:0]        nonce_limit,
  input  logic [255:0]       target,
  nonce_scheduler_if.master  core,
  output logic               busy,
  output logic               found,
  output logic [31:0]        found_nonce,
  output logic               exhausted,
  output logic               fault,
  output logic [CNT_W-1:0]   attempts
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, CHECK, FOUND, DONE, FAULT
  } stateT;

  stateT            stateReg, stateNext;
  logic [31:0]      nonceReg, limitReg, foundNonceReg;
  logic [255:0]     targetReg, hashReg;
  logic [CNT_W-1:0] attemptsReg;
  logic [TW-1:0]    timerReg;
  logic [7:0]       wordLt, wordEq;
  logic             hashHit, timedOut, acceptStart, doCheck;

  // Word-sliced magnitude compare keeps the 256-bit carry chain short.
  for (genvar gi = 0; gi < 8; gi++) begin : gWord
    assign wordLt[gi] = hashReg[gi*32 +: 32] <  targetReg[gi*32 +: 32];
    assign wordEq[gi] = hashReg[gi*32 +: 32] == targetReg[gi*32 +: 32];
  end

  always_comb begin
    hashHit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hashHit = wordLt[i] | (wordEq[i] & hashHit);
    end
  end

  assign timedOut = (timerReg == TW'(TIMEOUT - 1));

  always_comb begin
    stateNext   = stateReg;
    acceptStart = 1'b0;
    doCheck     = 1'b0;
    if (abort) begin
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE, FOUND, DONE, FAULT: begin
          if (start) begin
            acceptStart = 1'b1;
            stateNext   = LAUNCH;
          end
        end
        LAUNCH: stateNext = WAIT;
        WAIT: begin
          if (core.core_done) stateNext = CHECK;
          else if (timedOut)  stateNext = FAULT;
        end
        CHECK: begin
          doCheck = 1'b1;
          if (hashHit)                   stateNext = FOUND;
          else if (nonceReg == limitReg) stateNext = DONE;
          else                           stateNext = LAUNCH;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg      <= IDLE;
      nonceReg      <= '0;
      limitReg      <= '0;
      targetReg     <= '0;
      hashReg       <= '0;
      foundNonceReg <= '0;
      attemptsReg   <= '0;
      timerReg      <= '0;
    end else begin
      stateReg <= stateNext;
      if (acceptStart) begin
        nonceReg    <= nonce_base;
        limitReg    <= nonce_limit;
        targetReg   <= target;
        attemptsReg <= '0;
      end
      if (stateReg == LAUNCH) begin
        timerReg <= '0;
      end else if (stateReg == WAIT) begin
        timerReg <= timerReg + 1'b1;
      end
      if (stateReg == WAIT && core.core_done && !abort) begin
        hashReg <= core.core_hash;
      end
      if (doCheck) begin
        attemptsReg <= attemptsReg + 1'b1;
        if (hashHit) begin
          foundNonceReg <= nonceReg;
        end else if (nonceReg != limitReg) begin
          nonceReg <= nonceReg + 32'd1;
        end
      end
    end
  end

  // Gated by reset so a search caught in LAUNCH never fires the core during reset.
  assign core.core_start = (stateReg == LAUNCH) && !reset;
  assign core.core_nonce = nonceReg;

  assign busy        = (stateReg == LAUNCH) || (stateReg == WAIT) || (stateReg == CHECK);
  assign found       = (stateReg == FOUND);
  assign exhausted   = (stateReg == DONE);
  assign fault       = (stateReg == FAULT);
  assign found_nonce = foundNonceReg;
  assign attempts    = attemptsReg;

endmodule
